plastic_neuron_mac: RTL and testbench

PLASTIC_NEURON_MAC -- requirements
Module: plastic_neuron_mac

---
 rtl/plastic_neuron_mac.sv | 166 ++++++++++++++++
 tb/tb_plastic_neuron_mac.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/plastic_neuron_mac.sv
// plastic_neuron_mac
//   A single neuron: multiply-accumulate of N_IN signed inputs against N_IN
//   stored weights, one synapse per cycle, with an optional error-driven
//   weight update (delta = (x*err) >>> LR_SHIFT, saturating) after each result.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/ready    input vector handshake, in_data packs synapse i at [i*DW +: DW]
//   learn_en          sampled at the result handshake: 1 -> learn, 0 -> idle
//   err_valid/ready   error sample handshake, err_data signed DW
//   out_valid/ready   result handshake, out_data signed ACC_W (0 when not valid)
//   wt_sel, wt_rdata  combinational weight readback
//   dbg_state         current FSM state (IDLE=0, MAC=1, OUT=2, LEARN=3)
//
// Handshake rule for every channel: a transfer happens on a rising edge where
// valid and ready are both 1; the producer holds data stable until then.

module plastic_neuron_mac #(
    parameter int N_IN     = 4,
    parameter int DW       = 16,
    parameter int WW       = 16,
    parameter int ACC_W    = 40,
    parameter int LR_SHIFT = 4,
    parameter int W_INIT   = 1000,
    localparam int CW      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*DW-1:0]    in_data,
    input  logic                  learn_en,
    input  logic                  err_valid,
    output logic                  err_ready,
    input  logic [DW-1:0]         err_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    input  logic [CW-1:0]         wt_sel,
    output logic [WW-1:0]         wt_rdata,
    output logic [1:0]            dbg_state
);

    localparam int PW = DW + WW;
    // Wide enough to hold w + delta without overflow before saturation.
    localparam int SW = ((2 * DW > WW) ? 2 * DW : WW) + 1;
    localparam logic [CW-1:0] LAST = CW'(N_IN - 1);
    localparam logic signed [SW-1:0] W_MAX = $signed({{(SW-WW+1){1'b0}}, {(WW-1){1'b1}}});
    localparam logic signed [SW-1:0] W_MIN = $signed({{(SW-WW+1){1'b1}}, {(WW-1){1'b0}}});

    typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2, LEARN = 2'd3} state_t;

    state_t                  state_q, state_d;
    logic [N_IN*DW-1:0]      x_q, x_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [DW-1:0]    err_q, err_d;
    logic                    cap_q, cap_d;      // error captured, updates in progress
    logic signed [WW-1:0]    w_q [N_IN];

    logic                    w_we;
    logic signed [WW-1:0]    w_new;

    // Operands of the currently selected synapse.
    logic signed [DW-1:0]    x_cur;
    logic signed [WW-1:0]    w_cur;
    logic signed [PW-1:0]    mac_prod;
    logic signed [2*DW-1:0]  lrn_prod;
    logic signed [2*DW-1:0]  delta;
    logic signed [SW-1:0]    w_sum;

    assign x_cur    = x_q[cnt_q*DW +: DW];
    assign w_cur    = w_q[cnt_q];
    assign mac_prod = $signed({{WW{x_cur[DW-1]}}, x_cur}) * $signed({{DW{w_cur[WW-1]}}, w_cur});
    assign lrn_prod = $signed({{DW{x_cur[DW-1]}}, x_cur}) * $signed({{DW{err_q[DW-1]}}, err_q});
    // Arithmetic shift of a signed value rounds toward minus infinity.
    assign delta    = lrn_prod >>> LR_SHIFT;
    assign w_sum    = $signed({{(SW-WW){w_cur[WW-1]}}, w_cur})
                    + $signed({{(SW-2*DW){delta[2*DW-1]}}, delta});

    always_comb begin
        if (w_sum > W_MAX)      w_new = W_MAX[WW-1:0];
        else if (w_sum < W_MIN) w_new = W_MIN[WW-1:0];
        else                    w_new = w_sum[WW-1:0];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cap_d   = cap_q;
        w_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + $signed({{(ACC_W-PW){mac_prod[PW-1]}}, mac_prod});
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    cap_d   = 1'b0;
                    state_d = learn_en ? LEARN : IDLE;
                end
            end
            LEARN: begin
                if (!cap_q) begin
                    if (err_valid) begin
                        err_d = err_data;
                        cap_d = 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    w_we  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        cap_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            cap_q   <= 1'b0;
            for (int i = 0; i < N_IN; i++) w_q[i] <= WW'(W_INIT);
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            cap_q   <= cap_d;
            if (w_we) w_q[cnt_q] <= w_new;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign err_ready = (state_q == LEARN) && !cap_q;
    assign out_data  = out_valid ? acc_q : '0;
    assign wt_rdata  = w_q[wt_sel];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_plastic_neuron_mac.sv
module tb_plastic_neuron_mac;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int WW   = 16;
  localparam int AW   = 40;
  localparam int LR   = 4;
  localparam int WI   = 1000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic          learn_en;
  logic          err_valid;
  logic          err_ready;
  logic [DW-1:0] err_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [1:0]    wt_sel;
  logic [WW-1:0] wt_rdata;
  logic [1:0]    dbg_state;

  plastic_neuron_mac #(
    .N_IN(N), .DW(DW), .WW(WW), .ACC_W(AW), .LR_SHIFT(LR), .W_INIT(WI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .learn_en(learn_en),
    .err_valid(err_valid), .err_ready(err_ready), .err_data(err_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wt_sel(wt_sel), .wt_rdata(wt_rdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_pass = 0;
  int n_total = 0;
  logic [AW-1:0] exp_q[$];
  longint w_m[N];
  int xv[N];
  int xfer_cnt = 0;

  always @(posedge clk) if (rst_n && out_valid && out_ready) xfer_cnt++;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic check_weights(input string tag);
    for (int i = 0; i < N; i++) begin
      wt_sel = 2'(i);
      #1;
      check(tag, $signed(wt_rdata), w_m[i]);
    end
  endtask

  // driver tasks
  task automatic prepare_vec(input int a, input int b, input int c, input int d);
    longint s;
    xv[0] = a; xv[1] = b; xv[2] = c; xv[3] = d;
    s = 0;
    for (int i = 0; i < N; i++) begin
      in_data[i*DW +: DW] = DW'(xv[i]);
      s += longint'(xv[i]) * w_m[i];
    end
    exp_q.push_back(AW'(s));
    in_valid = 1'b1;
  endtask

  task automatic accept_vec();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("accept_in_ready_low", in_ready, 0);
  endtask

  task automatic start_vec(input int a, input int b, input int c, input int d);
    check("idle_in_ready", in_ready, 1);
    prepare_vec(a, b, c, d);
    accept_vec();
  endtask

  task automatic wait_out(input int stall);
    logic [AW-1:0] e;
    e = '0;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (k < N) begin
        check("latency_valid_low", out_valid, 0);
        check("out_data_zero", $signed(out_data), 0);
      end else begin
        check("latency_valid_high", out_valid, 1);
        if (exp_q.size() == 0) check("scoreboard_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("out_data", $signed(out_data), $signed(e));
        end
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_data", $signed(out_data), $signed(e));
      check("hold_in_ready", in_ready, 0);
    end
  endtask

  task automatic handshake(input bit learn);
    int xb;
    xb = xfer_cnt;
    out_ready = 1'b1;
    learn_en  = learn;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    learn_en  = !learn;
    check("single_transfer", xfer_cnt - xb, 1);
    check("post_xfer_valid", out_valid, 0);
    check("post_xfer_data", $signed(out_data), 0);
    if (learn) begin
      check("learn_err_ready", err_ready, 1);
    end else begin
      check("idle_after_out", in_ready, 1);
      check("no_err_ready", err_ready, 0);
    end
  endtask

  task automatic give_err(input int err, input int wait_cycles);
    longint p, dl, sm;
    for (int k = 0; k < wait_cycles; k++) begin
      @(negedge clk);
      check("err_wait_ready", err_ready, 1);
    end
    err_valid = 1'b1;
    err_data  = DW'(err);
    @(posedge clk);
    @(negedge clk);
    err_valid = 1'b0;
    check("err_captured", err_ready, 0);
    for (int i = 0; i < N; i++) begin
      p  = longint'(xv[i]) * longint'(err);
      dl = p >>> LR;
      sm = w_m[i] + dl;
      if (sm > 32767) sm = 32767;
      if (sm < -32768) sm = -32768;
      w_m[i] = sm;
    end
  endtask

  task automatic wait_learn();
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      check("learn_done_idle", in_ready, (k == N) ? 1 : 0);
    end
  endtask

  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b0; err_valid = 1'b0; out_ready = 1'b0;
    #1;
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_err_ready"}, err_ready, 0);
    check({tag, "_out_data"}, $signed(out_data), 0);
    for (int i = 0; i < N; i++) w_m[i] = WI;
    exp_q.delete();
    check_weights({tag, "_weights"});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int learn_exp[N];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; learn_en = 1'b1;
    err_valid = 1'b0; err_data = '0; out_ready = 1'b0; wt_sel = '0;
    for (int i = 0; i < N; i++) w_m[i] = WI;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_err_ready", err_ready, 0);
    check("rst_out_data", $signed(out_data), 0);
    check_weights("rst_weights");

    // inference, accepted on the first edge after reset release
    prepare_vec(1, 2, 3, 4);
    @(negedge clk);
    rst_n = 1'b1;
    accept_vec();
    wait_out(0);
    check("infer_value", $signed(out_data), 10000);
    handshake(0);
    // learn_en was high except at the handshake edge
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("toggle_no_err_ready", err_ready, 0);
      check("toggle_idle", in_ready, 1);
    end
    check_weights("toggle_weights");

    // backpressure
    start_vec(1, 2, 3, 4);
    wait_out(3);
    handshake(0);

    // learning
    start_vec(16, -16, 0, 32);
    wait_out(0);
    handshake(1);
    give_err(16, 2);
    wait_learn();
    check_weights("learn_weights");
    learn_exp = '{1016, 984, 1000, 1032};
    for (int i = 0; i < N; i++) begin
      wt_sel = 2'(i);
      #1;
      check("learn_const", $signed(wt_rdata), learn_exp[i]);
    end

    // reset during MAC
    start_vec(5, 6, 7, 8);
    @(negedge clk);
    pulse_reset("rst_mac");

    // reset during LEARN weight updates
    start_vec(1, 1, 1, 1);
    wait_out(0);
    handshake(1);
    give_err(16, 0);
    @(negedge clk);
    pulse_reset("rst_learn");

    // saturation and floor rounding
    start_vec(32767, 0, 0, 0);
    wait_out(0);
    handshake(1);
    give_err(32767, 0);
    wait_learn();
    check_weights("sat_up_weights");
    start_vec(32767, 0, 0, 0);
    wait_out(0);
    handshake(1);
    give_err(32767, 1);
    wait_learn();
    wt_sel = 2'd0; #1;
    check("sat_hold_w0", $signed(wt_rdata), 32767);
    start_vec(-1, 0, 0, 0);
    wait_out(0);
    handshake(1);
    give_err(1, 0);
    wait_learn();
    wt_sel = 2'd0; #1;
    check("floor_w0", $signed(wt_rdata), 32766);
    check_weights("floor_weights");

    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
